// File: rtl/pwm_decode.sv
// pwm_decode: recovers the WIDTH-bit duty level from a counter-compared PWM stream.
// Define PWM_DECODE_CONFIRM_EN to publish only after two matching frames.
module pwm_decode #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] level,
  output logic             valid,
  output logic             frame_err
);
  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] PERIOD = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CW-1:0] LAST   = PERIOD - 1'b1;
  localparam logic [CW-1:0] ONE    = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    SEARCH,
    MEASURE
  } state_e;

  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic [CW-1:0] per_q, per_d;
  logic [CW-1:0] hi_q, hi_d;
  logic [CW-1:0] low_q, low_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic valid_q, valid_d;
  logic err_q, err_d;

  logic s, rise, pub, err;
  logic [WIDTH-1:0] pub_val;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
    prev_d  = s;
    state_d = state_q;
    per_d   = per_q;
    hi_d    = hi_q;
    low_d   = low_q;
    pub     = 1'b0;
    pub_val = '0;
    err     = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (rise) begin
          state_d = MEASURE;
          per_d   = ONE;
          hi_d    = ONE;
          low_d   = '0;
        end else if (!s) begin
          if (low_q == LAST) begin
            pub   = 1'b1;
            low_d = '0;
          end else begin
            low_d = low_q + 1'b1;
          end
        end else begin
          low_d = '0;
        end
      end
      MEASURE: begin
        if (per_q < PERIOD) begin
          if (rise) begin
            err   = 1'b1;
            per_d = ONE;
            hi_d  = ONE;
          end else begin
            per_d = per_q + 1'b1;
            hi_d  = hi_q + CW'(s);
          end
        end else if (rise) begin
          pub     = 1'b1;
          pub_val = hi_q[WIDTH-1:0];
          per_d   = ONE;
          hi_d    = ONE;
        end else if (!s) begin
          pub     = 1'b1;
          pub_val = hi_q[WIDTH-1:0];
          state_d = SEARCH;
          low_d   = ONE;
        end else begin
          // high spans the boundary: duty would be a full period
          err     = 1'b1;
          state_d = SEARCH;
          low_d   = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

`ifdef PWM_DECODE_CONFIRM_EN
  logic [WIDTH-1:0] cand_q, cand_d;
  logic cand_ok_q, cand_ok_d;

  always_comb begin
    cand_d    = cand_q;
    cand_ok_d = cand_ok_q;
    level_d   = level_q;
    valid_d   = 1'b0;
    err_d     = err;
    if (pub) begin
      if (cand_ok_q && (cand_q == pub_val)) begin
        level_d = pub_val;
        valid_d = 1'b1;
      end
      cand_d    = pub_val;
      cand_ok_d = 1'b1;
    end else if (err) begin
      cand_ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= '0;
      cand_ok_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cand_ok_q <= cand_ok_d;
    end
  end
`else
  always_comb begin
    level_d = pub ? pub_val : level_q;
    valid_d = pub;
    err_d   = err;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      per_q   <= '0;
      hi_q    <= '0;
      low_q   <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      low_q   <= low_d;
      level_q <= level_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign level     = level_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_pwm_decode.sv
// tb_pwm_decode: directed and random PWM frames checked against a
// frame-window reference model of the decoder.
module tb_pwm_decode;
  localparam int WIDTH = 3;
  localparam int SYNC  = 2;
  localparam int P     = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_in = 1'b0;
  logic [WIDTH-1:0] level;
  logic valid;
  logic frame_err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int val_seen = 0;

  bit pipe[$];
  bit shist[$];
  bit m_meas;
  int m_start;
  int m_zeros;
  int k;
  int exp_level;
  bit exp_valid;
  bit exp_err;
  bit c_ok;
  int c_val;

  always #5 clk = ~clk;

  pwm_decode #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .level(level),
    .valid(valid),
    .frame_err(frame_err)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe = {};
    for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
    shist = {};
    m_meas = 0;
    m_start = 0;
    m_zeros = 0;
    k = 0;
    exp_level = 0;
    exp_valid = 0;
    exp_err = 0;
    c_ok = 0;
    c_val = 0;
  endtask

  task automatic publish(int v);
`ifdef PWM_DECODE_CONFIRM_EN
    if (c_ok && c_val == v) begin
      exp_level = v;
      exp_valid = 1;
    end
    c_val = v;
    c_ok = 1;
`else
    exp_level = v;
    exp_valid = 1;
`endif
  endtask

  task automatic fault();
    exp_err = 1;
    c_ok = 0;
  endtask

  // One evaluation per clock on the synchronized sample stream.
  task automatic model_step(bit p);
    bit s;
    bit pv;
    bit r;
    int hi;
    s = pipe.pop_front();
    pipe.push_back(p);
    pv = (shist.size() > 0) ? shist[$] : 1'b0;
    r = s && !pv;
    shist.push_back(s);
    exp_valid = 0;
    exp_err = 0;
    if (m_meas) begin
      if (k - m_start < P) begin
        if (r) begin
          fault();
          m_start = k;
        end
      end else begin
        hi = 0;
        for (int i = m_start; i < k; i++) hi += int'(shist[i]);
        if (r) begin
          publish(hi % P);
          m_start = k;
        end else if (!s) begin
          publish(hi % P);
          m_meas = 0;
          m_zeros = 1;
        end else begin
          fault();
          m_meas = 0;
          m_zeros = 0;
        end
      end
    end else if (r) begin
      m_meas = 1;
      m_start = k;
    end else if (!s) begin
      m_zeros++;
      if (m_zeros == P) begin
        publish(0);
        m_zeros = 0;
      end
    end else begin
      m_zeros = 0;
    end
    k++;
  endtask

  task automatic cycle(bit p);
    pwm_in = p;
    @(posedge clk);
    model_step(p);
    @(negedge clk);
    check("valid", valid, exp_valid);
    check("frame_err", frame_err, exp_err);
    check("level", level, exp_level);
    check("excl", valid & frame_err, 0);
    if (valid) val_seen++;
    if (frame_err) err_seen++;
  endtask

  task automatic frame(int lv, int len);
    for (int i = 0; i < len; i++) cycle(i < lv);
  endtask

  initial begin
    int lv;
    int len;
    int reps;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_valid", valid, 0);
    check("rst_err", frame_err, 0);
    rst_n = 1'b1;

    repeat (24) cycle(1'b0);
    check("l0_level", level, 0);

    err_seen = 0;
    repeat (6) frame(5, P);
    check("l5_err", err_seen, 0);
    check("l5_level", level, exp_level);

    repeat (4) frame(7, P);
    repeat (4) frame(1, P);
    repeat (4) frame(2, P);
    repeat (4) frame(6, P);
    check("sw_level", level, 6);

    frame(3, 6);
    repeat (4) frame(3, P);

    repeat (3) frame(4, P);
    err_seen = 0;
    val_seen = 0;
    repeat (20) cycle(1'b1);
    check("hold_err", err_seen, 1);
    check("hold_level", level, 4);
    repeat (16) cycle(1'b0);

    repeat (3) frame(3, P);
    frame(3, 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) frame(3, P);
    check("post_rst_level", level, 3);

    repeat (3) frame(3, P);
    frame(4, P);
    repeat (3) frame(3, P);

    repeat (40) begin
      lv = $urandom_range(0, P - 1);
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 12) : P;
        frame(lv, len);
      end
    end
    repeat (20) cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_decode.md
Name: pwm_decode

Overview:
- Receive-side counterpart of the counter-compared PWM output stage. It recovers the WIDTH-bit duty level from a PWM waveform. Waveform model: frame of PERIOD = 2^WIDTH clocks; output high for the first `level` clocks of each frame.
- Used for loopback self-test of the left/right PWM channels.
- Also lets one die decode another die's PWM as a control input.

Parameters:
- WIDTH, 3, level bits; PERIOD = 2^WIDTH clocks per frame.
- SYNC_STAGES, 2, input synchronizer depth (>=2).

Ports:
- clk  input  1  system clock (same domain as the PWM generator's counter clock)
- rst_n  input  1  asynchronous active-low reset
- pwm_in  input  1  PWM waveform, asynchronous to clk
- level  output  WIDTH  last decoded duty level
- valid  output  1  one-clock pulse when level is (re)published
- frame_err  output  1  one-clock pulse on a malformed frame

Behaviour:
Input conditioning:
- pwm_in passes through a SYNC_STAGES flop chain to give s. Chain resets to 0.
- prev register holds the previous s, resets to 0.
- rise = s & ~prev.
- Input high at reset release therefore produces one rise.

Registers:
- per_cnt, hi_cnt, low_cnt: WIDTH+1 bits each, reset 0.
- state: reset to SEARCH.
- level, valid, frame_err: all registered, reset 0.

State SEARCH:
- rise: go to MEASURE; per_cnt=1, hi_cnt=1 (the rise clock counts as high); low_cnt=0.
- s==0, low_cnt==PERIOD-1: publish level=0, valid=1; low_cnt=0.
- s==0 otherwise: low_cnt+1.
- s==1, no rise: low_cnt=0; no publish.

State MEASURE, per_cnt<PERIOD:
- rise: early edge. frame_err=1, no publish; per_cnt=1, hi_cnt=1; stay in MEASURE.
- else: per_cnt+1; hi_cnt+s.

State MEASURE, per_cnt==PERIOD (frame-boundary clock):
- rise: publish level=hi_cnt[WIDTH-1:0], valid=1; per_cnt=1, hi_cnt=1; stay.
- no rise, s==0: publish level=hi_cnt, valid=1; go to SEARCH with low_cnt=1 (this clock counts).
- no rise, s==1: the high level spans the boundary, i.e. duty >= PERIOD. frame_err=1, no publish, level unchanged; go to SEARCH.

General rules:
- Valid frames always give hi_cnt <= PERIOD-1, so truncation is lossless.
- Duty 0 republishes 0 every PERIOD clocks.
- valid and frame_err are never both 1 in the same clock.
- level holds between publishes.
- Latency: the valid/level update appears 1 clk after the boundary clock is evaluated on s. Pin to valid is SYNC_STAGES+1 clocks after the boundary edge is sampled.
- rst_n low at any time, including mid-frame: all state returns to reset values immediately. The first frame after release is discarded; only a rise starts measurement.

Optional Feature:
- Macro: PWM_DECODE_CONFIRM_EN.
- Defined: each would-be publish is a candidate. level updates and valid pulses only when the candidate equals the immediately preceding candidate. A 1-bit cand_ok flag and a WIDTH-bit cand register are added. frame_err clears cand_ok; reset clears both.
- Net effect: one extra frame of latency, and single corrupted frames are rejected.
- Not defined: every publish updates level and pulses valid as described above.

Test Plan:
- Reference generator at level 5, PERIOD 8 (high 5, low 3): after the first full frame, level=5 with valid exactly every 8 clocks; frame_err never asserts.
- Level 0 (constant low) after reset: level=0 with valid every 8 clocks. Level 7 (high 7, low 1): level=7 every 8 clocks. Level 1: level=1.
- Switch generator from 2 to 6 at a frame boundary: the next valid carries 6 and no spurious intermediate value appears. With PWM_DECODE_CONFIRM_EN, 6 appears one frame later.
- Rise 6 clocks after the previous rise: frame_err pulses once, no valid that frame; the following 8-clock frames decode normally.
- Hold pwm_in high for 20 clocks after a valid frame: exactly one frame_err, no valid while high; level holds its old value.
- Assert rst_n mid-frame at level 3: level=0, valid=0 immediately. After release, the first valid arrives at the second rise (value 3). With CONFIRM_EN, inject one corrupted 4-high frame into a 3 stream: level stays 3.
